// File: rtl/timer_in_conditioner.sv
// Event-pin conditioner for the timer: synchroniser, glitch filter, edge select
// and prescaler producing a one-clock count pulse, configured over the timer bus.
module timer_in_conditioner #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] FILT_RST    = 8'd3,
    parameter logic [7:0] PSC_RST     = 8'd0
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic [5:0] addr,
    input  logic       wr_en,
    input  logic       mod_en,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       pin_in,
    output logic       cnt_pulse,
    output logic       pin_level
);

    localparam logic [5:0] ADDR_CTRL = 6'h00;
    localparam logic [5:0] ADDR_FILT = 6'h01;
    localparam logic [5:0] ADDR_PSC  = 6'h02;
    localparam logic [5:0] ADDR_STAT = 6'h03;

    logic [2:0]             ctrl_reg;
    logic [7:0]             filt_reg;
    logic [7:0]             psc_reg;
    logic                   glitch_reg, glitch_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   f_reg, f_next;
    logic                   f_d_reg;
    logic [7:0]             fcnt_reg, fcnt_next;
    logic [7:0]             pcnt_reg, pcnt_next;
    logic                   pulse_reg, pulse_next;

    logic bus_wr, wr_ctrl, wr_filt, wr_psc, wr_stat;
    logic s, glitch_set, qual_edge;

    assign bus_wr  = mod_en & wr_en;
    assign wr_ctrl = bus_wr & (addr == ADDR_CTRL);
    assign wr_filt = bus_wr & (addr == ADDR_FILT);
    assign wr_psc  = bus_wr & (addr == ADDR_PSC);
    assign wr_stat = bus_wr & (addr == ADDR_STAT);

    assign s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ctrl_reg   <= 3'd0;
            filt_reg   <= FILT_RST;
            psc_reg    <= PSC_RST;
            glitch_reg <= 1'b0;
            sync_reg   <= '0;
            f_reg      <= 1'b0;
            f_d_reg    <= 1'b0;
            fcnt_reg   <= 8'd0;
            pcnt_reg   <= 8'd0;
            pulse_reg  <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl_reg <= wdata[2:0];
            if (wr_filt) filt_reg <= wdata;
            if (wr_psc)  psc_reg  <= wdata;
            glitch_reg <= glitch_next;
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pin_in};
            f_reg      <= f_next;
            f_d_reg    <= f_reg;
            fcnt_reg   <= fcnt_next;
            pcnt_reg   <= pcnt_next;
            pulse_reg  <= pulse_next;
        end
    end

    // Filter: the level follows s only after a mismatch run longer than FILT.
    always_comb begin
        f_next     = f_reg;
        fcnt_next  = fcnt_reg;
        glitch_set = 1'b0;
        if (s == f_reg) begin
            fcnt_next  = 8'd0;
            glitch_set = (fcnt_reg != 8'd0);
        end else if (fcnt_reg >= filt_reg) begin
            f_next    = s;
            fcnt_next = 8'd0;
        end else if (fcnt_reg != 8'hff) begin
            fcnt_next = fcnt_reg + 8'd1;
        end
        if (wr_filt) begin
            f_next    = f_reg;
            fcnt_next = 8'd0;
        end
    end

    // A new glitch outranks a simultaneous write-one-to-clear.
    assign glitch_next = glitch_set | (glitch_reg & ~(wr_stat & wdata[1]));

    assign qual_edge = (ctrl_reg[1] &  f_reg & ~f_d_reg) |
                       (ctrl_reg[2] & ~f_reg &  f_d_reg);

    always_comb begin
        pcnt_next  = pcnt_reg;
        pulse_next = 1'b0;
        if (!ctrl_reg[0] || wr_psc || (wr_ctrl && !wdata[0])) begin
            pcnt_next = 8'd0;
        end else if (qual_edge) begin
            if (pcnt_reg == psc_reg) begin
                pcnt_next  = 8'd0;
                pulse_next = 1'b1;
            end else begin
                pcnt_next = pcnt_reg + 8'd1;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (mod_en && !wr_en) begin
            case (addr)
                ADDR_CTRL: rdata = {5'd0, ctrl_reg};
                ADDR_FILT: rdata = filt_reg;
                ADDR_PSC:  rdata = psc_reg;
                ADDR_STAT: rdata = {6'd0, glitch_reg, f_reg};
                default:   rdata = 8'h00;
            endcase
        end
    end

    assign cnt_pulse = pulse_reg;
    assign pin_level = f_reg;

endmodule

// File: tb/tb_timer_in_conditioner.sv
// Directed and randomized checks of timer_in_conditioner against a segment-level
// model: a pin run survives the filter when it lasts at least FILT+1 cycles.
module tb_timer_in_conditioner;

    logic       clk = 1'b0;
    logic       rst_b = 1'b0;
    logic [5:0] addr = 6'd0;
    logic       wr_en = 1'b0;
    logic       mod_en = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       pin_in = 1'b0;
    logic       cnt_pulse;
    logic       pin_level;

    int passed = 0;
    int total = 0;
    int pulse_cnt = 0;
    int double_cnt = 0;
    logic prev_pulse = 1'b0;

    always #5 clk = ~clk;

    timer_in_conditioner dut (
        .clk(clk), .rst_b(rst_b), .addr(addr), .wr_en(wr_en), .mod_en(mod_en),
        .wdata(wdata), .rdata(rdata), .pin_in(pin_in), .cnt_pulse(cnt_pulse),
        .pin_level(pin_level)
    );

    always @(negedge clk) begin
        if (cnt_pulse) pulse_cnt++;
        if (cnt_pulse && prev_pulse) double_cnt++;
        prev_pulse = cnt_pulse;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [5:0] a, input logic [7:0] d);
        addr = a; wdata = d; mod_en = 1'b1; wr_en = 1'b1;
        @(posedge clk);
        #1;
        mod_en = 1'b0; wr_en = 1'b0;
        $display("wr addr=%0h data=%02h", a, d);
    endtask

    task automatic reg_read(input logic [5:0] a, output logic [7:0] d);
        addr = a; mod_en = 1'b1; wr_en = 1'b0;
        #1;
        d = rdata;
        mod_en = 1'b0;
        $display("rd addr=%0h data=%02h", a, d);
    endtask

    logic [7:0] rd;
    int base, lat;
    int m_f, m_g, m_edges, filt, psc, edge_sel, seg_len;
    logic v;
    int exp_cum [6] = '{0, 0, 1, 1, 1, 2};

    initial begin
        // Reset state
        #1;
        check("rst_pulse", cnt_pulse, 0);
        check("rst_level", pin_level, 0);
        wait_cycles(2);
        rst_b = 1'b1;
        wait_cycles(1);
        reg_read(6'h00, rd); check("rst_ctrl", rd, 8'h00);
        reg_read(6'h01, rd); check("rst_filt", rd, 8'h03);
        reg_read(6'h02, rd); check("rst_psc", rd, 8'h00);
        reg_read(6'h03, rd); check("rst_stat", rd, 8'h00);
        reg_read(6'h2a, rd); check("unmapped_rd", rd, 8'h00);
        #1;
        check("idle_rdata", rdata, 8'h00);

        // Rising edge latency with defaults
        reg_write(6'h00, 8'h03);
        base = pulse_cnt;
        lat = 0;
        pin_in = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (cnt_pulse && lat == 0) lat = n;
        end
        check("latency", lat, 7);
        check("single_pulse", pulse_cnt - base, 1);
        check("level_high", pin_level, 1);
        $display("latency step: %0d clocks", lat);

        // Glitch rejection and W1C
        base = pulse_cnt;
        pin_in = 1'b0; wait_cycles(12);
        check("fall_no_pulse", pulse_cnt - base, 0);
        pin_in = 1'b1; wait_cycles(3);
        pin_in = 1'b0; wait_cycles(12);
        check("glitch_no_pulse", pulse_cnt - base, 0);
        reg_read(6'h03, rd); check("stat_glitch", rd, 8'h02);
        pin_in = 1'b1; wait_cycles(4);
        pin_in = 1'b0; wait_cycles(12);
        check("filt_plus1_pulse", pulse_cnt - base, 1);
        reg_write(6'h03, 8'h02);
        reg_read(6'h03, rd); check("stat_w1c", rd, 8'h00);

        // Prescaler 2 on both edges
        reg_write(6'h02, 8'h02);
        reg_write(6'h00, 8'h07);
        base = pulse_cnt;
        for (int t = 0; t < 6; t++) begin
            pin_in = ~pin_in;
            wait_cycles(10);
            check($sformatf("psc2_toggle%0d", t + 1), pulse_cnt - base, exp_cum[t]);
        end

        // Falling-only selection
        reg_write(6'h02, 8'h00);
        reg_write(6'h00, 8'h05);
        base = pulse_cnt;
        pin_in = 1'b1; wait_cycles(10);
        check("fallsel_rise", pulse_cnt - base, 0);
        pin_in = 1'b0; wait_cycles(10);
        check("fallsel_fall", pulse_cnt - base, 1);

        // Lowering PSC below pcnt clears without a spurious pulse
        reg_write(6'h00, 8'h03);
        reg_write(6'h02, 8'h03);
        base = pulse_cnt;
        repeat (2) begin
            pin_in = 1'b1; wait_cycles(10);
            pin_in = 1'b0; wait_cycles(10);
        end
        reg_write(6'h02, 8'h00);
        wait_cycles(3);
        check("psc_lower_nopulse", pulse_cnt - base, 0);
        pin_in = 1'b1; wait_cycles(10);
        check("psc_lower_next", pulse_cnt - base, 1);
        pin_in = 1'b0; wait_cycles(10);

        // Reset mid-filter
        base = pulse_cnt;
        pin_in = 1'b1; wait_cycles(3);
        rst_b = 1'b0; #1;
        check("midfilt_level", pin_level, 0);
        check("midfilt_pulse", cnt_pulse, 0);
        wait_cycles(1);
        rst_b = 1'b1;
        reg_read(6'h00, rd); check("midfilt_ctrl", rd, 8'h00);
        reg_read(6'h01, rd); check("midfilt_filt", rd, 8'h03);
        wait_cycles(10);
        check("midfilt_nopulse", pulse_cnt - base, 0);

        // Reset with a pulse pending and pcnt at 1
        reg_write(6'h00, 8'h03);
        reg_write(6'h02, 8'h01);
        pin_in = 1'b0; wait_cycles(10);
        pin_in = 1'b1; wait_cycles(10);
        pin_in = 1'b0; wait_cycles(10);
        base = pulse_cnt;
        pin_in = 1'b1; wait_cycles(6);
        rst_b = 1'b0; #1;
        check("midpsc_pulse", cnt_pulse, 0);
        check("midpsc_level", pin_level, 0);
        wait_cycles(1);
        rst_b = 1'b1;
        wait_cycles(10);
        check("midpsc_dropped", pulse_cnt - base, 0);
        reg_write(6'h00, 8'h03);
        reg_write(6'h02, 8'h01);
        pin_in = 1'b0; wait_cycles(10);
        pin_in = 1'b1; wait_cycles(10);
        check("restart_first", pulse_cnt - base, 0);
        pin_in = 1'b0; wait_cycles(10);
        pin_in = 1'b1; wait_cycles(10);
        check("restart_second", pulse_cnt - base, 1);

        // Randomized pin runs against the segment model
        for (int trial = 0; trial < 8; trial++) begin
            filt = $urandom_range(0, 4);
            psc = $urandom_range(0, 3);
            edge_sel = $urandom_range(0, 3);
            reg_write(6'h00, 8'((edge_sel << 1) | 1));
            reg_write(6'h01, 8'(filt));
            reg_write(6'h02, 8'(psc));
            reg_write(6'h03, 8'h02);
            base = pulse_cnt;
            m_f = int'(pin_in);
            m_g = 0;
            m_edges = 0;
            for (int seg = 0; seg < 10; seg++) begin
                v = ~pin_in;
                seg_len = $urandom_range(1, 6);
                if (seg == 9) seg_len += 15;
                pin_in = v;
                wait_cycles(seg_len);
                if (int'(v) != m_f) begin
                    if (seg_len >= filt + 1) begin
                        m_f = int'(v);
                        if ((v && (edge_sel & 1) != 0) || (!v && (edge_sel & 2) != 0))
                            m_edges++;
                    end else begin
                        m_g = 1;
                    end
                end
            end
            $display("trial %0d filt=%0d psc=%0d edge=%0d edges=%0d pulses=%0d",
                     trial, filt, psc, edge_sel, m_edges, pulse_cnt - base);
            check($sformatf("rand%0d_pulses", trial), pulse_cnt - base, m_edges / (psc + 1));
            check($sformatf("rand%0d_level", trial), pin_level, m_f);
            reg_read(6'h03, rd);
            check($sformatf("rand%0d_stat", trial), rd, 8'((m_g << 1) | m_f));
        end
        check("pulse_width", double_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
